// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a single-port word-wide data memory.
// Big-endian lanes; sub-word stores are done as read-modify-write.
module mem_access_unit #(
    parameter int unsigned ADDR_W          = 32,
    parameter bit          ERR_ON_BAD_SIZE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic              mem_read,
    output logic              mem_write
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [1:0]        size_q,     size_d;
    logic              write_q,    write_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       word_q,     word_d;
    logic              err_q,      err_d;

    logic [1:0]  eff_size;
    logic        bad_size;
    logic        misaligned;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Size 11 is either rejected or folded into a word access before latching.
    always_comb begin
        bad_size   = (req_size == 2'b11) && ERR_ON_BAD_SIZE;
        eff_size   = (req_size == 2'b11) ? SZ_WORD : req_size;
        misaligned = ((eff_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                     ((eff_size == SZ_HALF) && req_addr[0]);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    size_d     = eff_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    word_d     = '0;
                    err_d      = bad_size || misaligned;
                    if (bad_size || misaligned)
                        state_d = S_RESP;
                    else if (req_write && (eff_size == SZ_WORD))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                word_d  = mem_read_data;
                state_d = write_q ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1])
                    merged[15:0] = wdata_q[15:0];
                else
                    merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
        half_sel = addr_q[1] ? word_q[15:0] : word_q[31:16];
        case (size_q)
            SZ_BYTE: load_data = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_data = word_q;
        endcase
    end

    // Outputs decode straight from state_q so an async reset in WR drops mem_write at once.
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        mem_read       = (state_q == S_RD);
        mem_write      = (state_q == S_WR);
        mem_address    = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_write_data = mem_write ? merged : '0;
        resp_valid     = (state_q == S_RESP);
        resp_err       = resp_valid && err_q;
        resp_rdata     = (resp_valid && !err_q && !write_q) ? load_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array data memory plus a
// byte-level reference model of load/store semantics.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.ADDR_W(32), .ERR_ON_BAD_SIZE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [11:0] ma;
    assign ma = mem_address[11:0];
    assign mem_read_data = mem_read ? {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]} : 32'h0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    bit both_flag = 0, align_flag = 0, idle_resp_flag = 0, idle_bus_flag = 0;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma]         <= mem_write_data[31:24];
            mem[ma + 12'd1] <= mem_write_data[23:16];
            mem[ma + 12'd2] <= mem_write_data[15:8];
            mem[ma + 12'd3] <= mem_write_data[7:0];
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) both_flag = 1;
        if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) align_flag = 1;
        if (!resp_valid && (resp_rdata != 0 || resp_err)) idle_resp_flag = 1;
        if (!mem_read && !mem_write && (mem_address != 0 || mem_write_data != 0)) idle_bus_flag = 1;
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[12'(a + 32'(i))]);
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] t = wd;
        for (int i = nbytes(sz) - 1; i >= 0; i--) begin
            ref_mem[12'(a + 32'(i))] = t[7:0];
            t = t >> 8;
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[12'(a + 32'(i))]     = w[31-8*i -: 8];
            ref_mem[12'(a + 32'(i))] = w[31-8*i -: 8];
        end
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        return {mem[12'(a)], mem[12'(a + 1)], mem[12'(a + 2)], mem[12'(a + 3)]};
    endfunction

    // Packed view: {extra_pulse, rdata, err, latency[4:0], reads[1:0], writes[1:0]}
    function automatic logic [42:0] pack_exp(input logic [31:0] rd, input bit e, input int lat,
                                             input int nr, input int nw);
        logic [4:0] l = lat[4:0];
        logic [1:0] r = nr[1:0];
        logic [1:0] w = nw[1:0];
        return {1'b0, rd, e, l, r, w};
    endfunction

    function automatic logic [42:0] model_txn(input bit w, input logic [1:0] sz, input logic uns,
                                              input logic [31:0] a);
        if (exp_err(sz, a)) return pack_exp(32'h0, 1, 1, 0, 0);
        if (!w) return pack_exp(ref_load(sz, uns, a), 0, 2, 1, 0);
        if (sz == 2'b10) return pack_exp(32'h0, 0, 2, 0, 1);
        return pack_exp(32'h0, 0, 3, 1, 1);
    endfunction

    task automatic do_req(input bit w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output logic [42:0] got);
        int guard = 0;
        int r0, w0, lat;
        logic [31:0] rd = '0;
        logic e = 1'b0, extra;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_write = ~w; req_unsigned = ~uns;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin lat = c; rd = resp_rdata; e = resp_err; break; end
        end
        @(negedge clk);
        extra = resp_valid;
        got = {extra, rd, e, lat[4:0], 2'(rd_cnt - r0), 2'(wr_cnt - w0)};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_write_data}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wd=%h required ready=1 rest 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_write_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wr;
        bit saw_resp = 0;
        poke(32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        req_write = 1; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL midwr_in_wr mem_write=%b required 1", mem_write); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_write, req_ready, mem_address} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL midwr_async_drop mem_write=%b ready=%b addr=%h required 0 1 0", mem_write, req_ready, mem_address);
        end
        repeat (2) begin @(negedge clk); if (resp_valid) saw_resp = 1; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (resp_valid) saw_resp = 1; end
        checks++;
        if (saw_resp !== 1'b0) begin errors++; $display("FAIL midwr_no_resp resp_seen=%b required 0", saw_resp); end
        checks++;
        if (peek(32'h40) !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL midwr_mem_kept got=%h required cafef00d", peek(32'h40));
        end
    endtask

    task automatic test_word_roundtrip;
        logic [42:0] got;
        do_req(1, 2'b10, 0, 32'h100, 32'h1234_5678, got);
        checks++;
        if (got !== pack_exp(32'h0, 0, 2, 0, 1)) begin errors++; $display("FAIL sw_txn got=%h required %h", got, pack_exp(32'h0, 0, 2, 0, 1)); end
        checks++;
        if (peek(32'h100) !== 32'h1234_5678) begin errors++; $display("FAIL sw_bytes got=%h required 12345678", peek(32'h100)); end
        do_req(0, 2'b10, 0, 32'h100, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'h1234_5678, 0, 2, 1, 0)) begin errors++; $display("FAIL lw_txn got=%h required %h", got, pack_exp(32'h1234_5678, 0, 2, 1, 0)); end
    endtask

    task automatic test_byte_rmw;
        logic [42:0] got;
        poke(32'h200, 32'h1122_3344);
        do_req(1, 2'b00, 0, 32'h202, 32'h5566_77AA, got);
        checks++;
        if (got !== pack_exp(32'h0, 0, 3, 1, 1)) begin errors++; $display("FAIL sb_txn got=%h required %h", got, pack_exp(32'h0, 0, 3, 1, 1)); end
        checks++;
        if (peek(32'h200) !== 32'h1122_AA44) begin errors++; $display("FAIL sb_word got=%h required 1122aa44", peek(32'h200)); end
        do_req(0, 2'b00, 0, 32'h202, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'hFFFF_FFAA, 0, 2, 1, 0)) begin errors++; $display("FAIL lb_txn got=%h required %h", got, pack_exp(32'hFFFF_FFAA, 0, 2, 1, 0)); end
        do_req(0, 2'b00, 1, 32'h202, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'h0000_00AA, 0, 2, 1, 0)) begin errors++; $display("FAIL lbu_txn got=%h required %h", got, pack_exp(32'h0000_00AA, 0, 2, 1, 0)); end
    endtask

    task automatic test_halfword;
        logic [42:0] got;
        poke(32'h204, 32'h0);
        do_req(1, 2'b01, 0, 32'h206, 32'h1234_8001, got);
        checks++;
        if (peek(32'h204) !== 32'h0000_8001) begin errors++; $display("FAIL sh_lo_word got=%h required 00008001", peek(32'h204)); end
        do_req(0, 2'b01, 0, 32'h206, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'hFFFF_8001, 0, 2, 1, 0)) begin errors++; $display("FAIL lh_txn got=%h required %h", got, pack_exp(32'hFFFF_8001, 0, 2, 1, 0)); end
        do_req(0, 2'b01, 1, 32'h206, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'h0000_8001, 0, 2, 1, 0)) begin errors++; $display("FAIL lhu_txn got=%h required %h", got, pack_exp(32'h0000_8001, 0, 2, 1, 0)); end
        do_req(1, 2'b01, 0, 32'h204, 32'hFFFF_7FFE, got);
        checks++;
        if (peek(32'h204) !== 32'h7FFE_8001) begin errors++; $display("FAIL sh_hi_word got=%h required 7ffe8001", peek(32'h204)); end
        do_req(0, 2'b01, 0, 32'h204, 32'h0, got);
        checks++;
        if (got !== pack_exp(32'h0000_7FFE, 0, 2, 1, 0)) begin errors++; $display("FAIL lh_hi_txn got=%h required %h", got, pack_exp(32'h0000_7FFE, 0, 2, 1, 0)); end
    endtask

    task automatic test_misalign;
        logic [42:0] got;
        bit          w  [5] = '{0, 1, 0, 0, 1};
        logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
        logic [31:0] a  [5] = '{32'h101, 32'h203, 32'h0, 32'h102, 32'h103};
        for (int i = 0; i < 5; i++) begin
            do_req(w[i], sz[i], 0, a[i], 32'hFFFF_FFFF, got);
            checks++;
            if (got !== pack_exp(32'h0, 1, 1, 0, 0)) begin
                errors++; $display("FAIL misalign_%0d got=%h required %h", i, got, pack_exp(32'h0, 1, 1, 0, 0));
            end
        end
        checks++;
        if (peek(32'h200) !== 32'h1122_AA44) begin errors++; $display("FAIL misalign_mem_kept got=%h required 1122aa44", peek(32'h200)); end
    endtask

    task automatic test_handshake;
        logic [31:0] a    [3] = '{32'h300, 32'h301, 32'h303};
        logic        uns  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] expd [3] = '{32'hFFFF_FFA1, 32'h0000_00B2, 32'hFFFF_FFD4};
        logic [31:0] got  [$];
        int acc_cyc [$];
        int idx = 0;
        bit rdy, ready_in_resp = 0;
        poke(32'h300, 32'hA1B2_C3D4);
        @(negedge clk);
        req_write = 0; req_size = 2'b00; req_unsigned = uns[0]; req_addr = a[0]; req_valid = 1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rdy = req_ready;
            if (resp_valid) begin got.push_back(resp_rdata); if (rdy) ready_in_resp = 1; end
            @(posedge clk); #1;
            if (rdy && req_valid) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 3) begin req_unsigned = uns[idx]; req_addr = a[idx]; end
                else req_valid = 0;
            end
            @(negedge clk);
        end
        req_valid = 0;
        checks++;
        if (acc_cyc.size() != 3 || got.size() != 3) begin
            errors++; $display("FAIL hs_counts accepts=%0d responses=%0d required 3 3", acc_cyc.size(), got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== expd[i]) begin errors++; $display("FAIL hs_resp_%0d got=%h required %h", i, got[i], expd[i]); end
            end
            checks++;
            if ((acc_cyc[1] - acc_cyc[0]) != 3 || (acc_cyc[2] - acc_cyc[1]) != 3) begin
                errors++; $display("FAIL hs_spacing gaps=%0d,%0d required 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        checks++;
        if (ready_in_resp !== 1'b0) begin errors++; $display("FAIL hs_ready_in_resp got=1 required 0"); end
    endtask

    task automatic test_random;
        logic [42:0] got, expv;
        int bad_bytes = 0;
        for (int i = 12'h800; i < 12'h900; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int t = 0; t < 80; t++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [1:0]  sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            logic [31:0] a  = 32'h800 + 32'($urandom_range(0, 252));
            bit          w  = 1'($urandom);
            logic        u  = 1'($urandom);
            logic [31:0] wd = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a - (a % nbytes(sz));
            expv = model_txn(w, sz, u, a);
            do_req(w, sz, u, a, wd, got);
            if (w && !exp_err(sz, a)) ref_store(sz, a, wd);
            checks++;
            if (got !== expv) begin
                errors++; $display("FAIL rand_%0d w=%0d sz=%0d u=%0d a=%h got=%h required %h", t, w, sz, u, a, got, expv);
            end
        end
        for (int i = 12'h800; i < 12'h900; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
        checks++;
        if (bad_bytes != 0) begin errors++; $display("FAIL rand_mem_image bad_bytes=%0d required 0", bad_bytes); end
        checks++;
        if ({both_flag, align_flag, idle_resp_flag, idle_bus_flag} !== 4'b0000) begin
            errors++;
            $display("FAIL bus_invariants both=%b unaligned=%b idle_resp=%b idle_bus=%b required 0000",
                     both_flag, align_flag, idle_resp_flag, idle_bus_flag);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin mem[i] = 8'h0; ref_mem[i] = 8'h0; end
        test_reset;
        test_reset_mid_wr;
        test_word_roundtrip;
        test_byte_rmw;
        test_halfword;
        test_misalign;
        test_handshake;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
